// File: rtl/nios_blink_mem_pkg.sv
// Shared types and constants for the Nios blink dual-port on-chip RAM.
package nios_blink_mem_pkg;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } mem_state_t;

   localparam int COLL_CNT_W = 16;

   function automatic bit read_latency_legal(input int rl);
      return (rl == 1) || (rl == 2);
   endfunction

endpackage

// File: rtl/nios_blink_ram_tdp.sv
// Behavioural true-dual-port byte-enabled RAM; reads return the word as it
// was before any write in the same cycle.
module nios_blink_ram_tdp #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 5120,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                en,
   input  logic [ADDR_W-1:0]   a_address,
   input  logic                a_read,
   input  logic                a_write,
   input  logic [DATA_W/8-1:0] a_byteenable,
   input  logic [DATA_W-1:0]   a_writedata,
   output logic [DATA_W-1:0]   a_readdata,
   input  logic [ADDR_W-1:0]   b_address,
   input  logic                b_read,
   input  logic                b_write,
   input  logic [DATA_W/8-1:0] b_byteenable,
   input  logic [DATA_W-1:0]   b_writedata,
   output logic [DATA_W-1:0]   b_readdata
);

   localparam int NUM_BYTES = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Callers never write the same word from both ports in one cycle.
   always_ff @(posedge clk) begin
      if (en) begin
         if (a_read) a_readdata <= mem[a_address];
         if (b_read) b_readdata <= mem[b_address];
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (a_write && a_byteenable[i]) mem[a_address][i*8 +: 8] <= a_writedata[i*8 +: 8];
            if (b_write && b_byteenable[i]) mem[b_address][i*8 +: 8] <= b_writedata[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/nios_blink_onchip_ram_dp.sv
// Dual Avalon-MM slave on-chip RAM: post-reset clear engine, s1-wins write
// arbitration, 1/2-cycle read pipeline, out-of-range masking, collision count.
module nios_blink_onchip_ram_dp
   import nios_blink_mem_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 5120,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clken,
   input  logic [ADDR_W-1:0]     s1_address,
   input  logic                  s1_chipselect,
   input  logic                  s1_read,
   input  logic                  s1_write,
   input  logic [DATA_W/8-1:0]   s1_byteenable,
   input  logic [DATA_W-1:0]     s1_writedata,
   output logic [DATA_W-1:0]     s1_readdata,
   output logic                  s1_readdatavalid,
   output logic                  s1_waitrequest,
   input  logic [ADDR_W-1:0]     s2_address,
   input  logic                  s2_chipselect,
   input  logic                  s2_read,
   input  logic                  s2_write,
   input  logic [DATA_W/8-1:0]   s2_byteenable,
   input  logic [DATA_W-1:0]     s2_writedata,
   output logic [DATA_W-1:0]     s2_readdata,
   output logic                  s2_readdatavalid,
   output logic                  s2_waitrequest,
   output logic                  busy,
   output logic [COLL_CNT_W-1:0] collision_cnt
);

   if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
   end

   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

   mem_state_t        state, state_nxt;
   logic [ADDR_W-1:0] clr_addr;
   logic              stall, clearing, collide;
   logic              s1_cmd, s1_wr_acc, s1_rd_acc, s1_in_range;
   logic              s2_cmd, s2_wr_acc, s2_rd_acc, s2_in_range;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         clr_addr <= '0;
      end else if (clken) begin
         state <= state_nxt;
         if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (clr_addr == CLR_LAST) state_nxt = ST_RUN;
         ST_RUN:   state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // Waitrequest is forced high by reset itself so no command slips in while it is held.
   assign stall          = ~reset_n | (state != ST_RUN) | ~clken;
   assign s1_waitrequest = stall;
   assign s2_waitrequest = stall;
   assign busy           = (state == ST_CLEAR);
   assign clearing       = (state == ST_CLEAR) & reset_n & clken;

   assign s1_cmd      = s1_chipselect & (s1_read | s1_write) & ~stall;
   assign s1_wr_acc   = s1_cmd & s1_write;
   assign s1_rd_acc   = s1_cmd & ~s1_write;
   assign s1_in_range = {1'b0, s1_address} < DEPTH_EXT;
   assign s2_cmd      = s2_chipselect & (s2_read | s2_write) & ~stall;
   assign s2_wr_acc   = s2_cmd & s2_write;
   assign s2_rd_acc   = s2_cmd & ~s2_write;
   assign s2_in_range = {1'b0, s2_address} < DEPTH_EXT;
   assign collide     = s1_wr_acc & s2_wr_acc & (s1_address == s2_address);

   logic [DATA_W-1:0] ram_q_a, ram_q_b;

   nios_blink_ram_tdp #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk          (clk),
      .en           (clken),
      .a_address    ((state == ST_CLEAR) ? clr_addr : s1_address),
      .a_read       (s1_rd_acc & s1_in_range),
      .a_write      (clearing | (s1_wr_acc & s1_in_range)),
      .a_byteenable ((state == ST_CLEAR) ? {(DATA_W/8){1'b1}} : s1_byteenable),
      .a_writedata  ((state == ST_CLEAR) ? {DATA_W{1'b0}} : s1_writedata),
      .a_readdata   (ram_q_a),
      .b_address    (s2_address),
      .b_read       (s2_rd_acc & s2_in_range),
      .b_write      (s2_wr_acc & s2_in_range & ~collide),
      .b_byteenable (s2_byteenable),
      .b_writedata  (s2_writedata),
      .b_readdata   (ram_q_b)
   );

   // Zero flag only moves on an accepted read, so stage-1 data holds between reads.
   logic [1:0]        p1_valid, p1_zero, out_valid;
   logic [DATA_W-1:0] p1_data  [2];
   logic [DATA_W-1:0] out_data [2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p1_valid <= '0;
         p1_zero  <= '1;
      end else if (clken) begin
         p1_valid <= {s2_rd_acc, s1_rd_acc};
         if (s1_rd_acc) p1_zero[0] <= ~s1_in_range;
         if (s2_rd_acc) p1_zero[1] <= ~s2_in_range;
      end
   end

   assign p1_data[0] = p1_zero[0] ? '0 : ram_q_a;
   assign p1_data[1] = p1_zero[1] ? '0 : ram_q_b;

   if (READ_LATENCY == 2) begin : g_lat2
      logic [1:0]        p2_valid;
      logic [DATA_W-1:0] p2_data [2];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            p2_valid   <= '0;
            p2_data[0] <= '0;
            p2_data[1] <= '0;
         end else if (clken) begin
            p2_valid <= p1_valid;
            for (int i = 0; i < 2; i++) begin
               if (p1_valid[i]) p2_data[i] <= p1_data[i];
            end
         end
      end

      assign out_valid   = p2_valid;
      assign out_data[0] = p2_data[0];
      assign out_data[1] = p2_data[1];
   end else begin : g_lat1
      assign out_valid   = p1_valid;
      assign out_data[0] = p1_data[0];
      assign out_data[1] = p1_data[1];
   end

   assign s1_readdatavalid = out_valid[0];
   assign s1_readdata      = out_data[0];
   assign s2_readdatavalid = out_valid[1];
   assign s2_readdata      = out_data[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         collision_cnt <= '0;
      end else if (collide && (collision_cnt != '1)) begin
         collision_cnt <= collision_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_nios_blink_onchip_ram_dp.sv
// Randomised bench for nios_blink_onchip_ram_dp with a word-array/queue reference
// model compared every cycle, plus literal checks of the directed scenarios.
module tb_nios_blink_onchip_ram_dp;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 20;
   localparam int ADDR_W = 5;
   localparam int RL     = 2;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              clken = 1'b1;
   logic [ADDR_W-1:0] s1_address = '0, s2_address = '0;
   logic              s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
   logic              s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
   logic [3:0]        s1_byteenable = '0, s2_byteenable = '0;
   logic [31:0]       s1_writedata = '0, s2_writedata = '0;
   logic [31:0]       s1_readdata, s2_readdata;
   logic              s1_readdatavalid, s2_readdatavalid;
   logic              s1_waitrequest, s2_waitrequest;
   logic              busy;
   logic [15:0]       collision_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nios_blink_onchip_ram_dp #(
      .DATA_W         (DATA_W),
      .DEPTH          (DEPTH),
      .ADDR_W         (ADDR_W),
      .READ_LATENCY   (RL),
      .CLEAR_ON_RESET (1)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .clken            (clken),
      .s1_address       (s1_address),
      .s1_chipselect    (s1_chipselect),
      .s1_read          (s1_read),
      .s1_write         (s1_write),
      .s1_byteenable    (s1_byteenable),
      .s1_writedata     (s1_writedata),
      .s1_readdata      (s1_readdata),
      .s1_readdatavalid (s1_readdatavalid),
      .s1_waitrequest   (s1_waitrequest),
      .s2_address       (s2_address),
      .s2_chipselect    (s2_chipselect),
      .s2_read          (s2_read),
      .s2_write         (s2_write),
      .s2_byteenable    (s2_byteenable),
      .s2_writedata     (s2_writedata),
      .s2_readdata      (s2_readdata),
      .s2_readdatavalid (s2_readdatavalid),
      .s2_waitrequest   (s2_waitrequest),
      .busy             (busy),
      .collision_cnt    (collision_cnt)
   );

   // Reference model: word array, clear countdown, per-port list of reads in flight with age.
   logic [31:0]       mmem [DEPTH];
   int                busy_left;
   logic [15:0]       m_coll;
   logic [31:0]       qd [2][8];
   int                qa [2][8];
   int                qn [2];
   logic [31:0]       mlast [2];
   bit                model_ready = 1'b0;
   logic              m_cs [2], m_rd [2], m_wr [2], m_wacc [2];
   logic [ADDR_W-1:0] m_a [2];
   logic [3:0]        m_be [2];
   logic [31:0]       m_wd [2];
   logic              m_collide;

   function automatic logic exp_valid(input int p);
      return (qn[p] > 0) && (qa[p][0] >= RL);
   endfunction

   function automatic logic [31:0] exp_data(input int p);
      return exp_valid(p) ? qd[p][0] : mlast[p];
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
         busy_left = DEPTH;
         m_coll = '0;
         for (int p = 0; p < 2; p++) begin
            qn[p] = 0;
            mlast[p] = '0;
         end
         model_ready = 1'b1;
      end else if (clken) begin
         for (int p = 0; p < 2; p++) begin
            if (qn[p] > 0 && qa[p][0] >= RL) begin
               mlast[p] = qd[p][0];
               for (int k = 0; k < 7; k++) begin
                  qd[p][k] = qd[p][k+1];
                  qa[p][k] = qa[p][k+1];
               end
               qn[p]--;
            end
            for (int k = 0; k < qn[p]; k++) qa[p][k]++;
         end
         if (busy_left > 0) begin
            busy_left--;
         end else begin
            m_cs[0] = s1_chipselect; m_rd[0] = s1_read; m_wr[0] = s1_write;
            m_a[0] = s1_address; m_be[0] = s1_byteenable; m_wd[0] = s1_writedata;
            m_cs[1] = s2_chipselect; m_rd[1] = s2_read; m_wr[1] = s2_write;
            m_a[1] = s2_address; m_be[1] = s2_byteenable; m_wd[1] = s2_writedata;
            for (int p = 0; p < 2; p++) begin
               m_wacc[p] = m_cs[p] && m_wr[p];
               if (m_cs[p] && m_rd[p] && !m_wr[p]) begin
                  qd[p][qn[p]] = (int'(m_a[p]) < DEPTH) ? mmem[m_a[p]] : 32'h0;
                  qa[p][qn[p]] = 1;
                  qn[p]++;
               end
            end
            m_collide = m_wacc[0] && m_wacc[1] && (m_a[0] == m_a[1]);
            if (m_collide && m_coll != 16'hFFFF) m_coll++;
            for (int p = 0; p < 2; p++) begin
               if (m_wacc[p] && int'(m_a[p]) < DEPTH && !(p == 1 && m_collide)) begin
                  for (int b = 0; b < 4; b++)
                     if (m_be[p][b]) mmem[m_a[p]][b*8 +: 8] = m_wd[p][b*8 +: 8];
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_ready) begin
         checkOutput("s1_readdatavalid", 32'(s1_readdatavalid), 32'(exp_valid(0)));
         checkOutput("s2_readdatavalid", 32'(s2_readdatavalid), 32'(exp_valid(1)));
         checkOutput("s1_readdata", s1_readdata, exp_data(0));
         checkOutput("s2_readdata", s2_readdata, exp_data(1));
         checkOutput("s1_waitrequest", 32'(s1_waitrequest), 32'(!reset_n || busy_left > 0 || !clken));
         checkOutput("s2_waitrequest", 32'(s2_waitrequest), 32'(!reset_n || busy_left > 0 || !clken));
         checkOutput("busy", 32'(busy), 32'(busy_left > 0));
         checkOutput("collision_cnt", 32'(collision_cnt), 32'(m_coll));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int p, input logic cs, input logic r, input logic w,
                                input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] d);
      if (p == 0) begin
         s1_chipselect = cs; s1_read = r; s1_write = w;
         s1_address = a; s1_byteenable = be; s1_writedata = d;
      end else begin
         s2_chipselect = cs; s2_read = r; s2_write = w;
         s2_address = a; s2_byteenable = be; s2_writedata = d;
      end
   endtask

   task automatic idleBoth();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic writeWord(input int p, input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] d);
      applyStimulus(p, 1'b1, 1'b0, 1'b1, a, be, d);
      tick();
      applyStimulus(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic readWord(input int p, input logic [ADDR_W-1:0] a, output logic [31:0] d);
      bit ok;
      applyStimulus(p, 1'b1, 1'b1, 1'b0, a, '0, '0);
      tick();
      applyStimulus(p, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      ok = 1'b0;
      d = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ((p == 0) ? s1_readdatavalid : s2_readdatavalid) begin
            d = (p == 0) ? s1_readdata : s2_readdata;
            ok = 1'b1;
            break;
         end
      end
      checkOutput("read_valid_seen", 32'(ok), 32'd1);
      tick();
   endtask

   // Counts busy cycles that are clock-enabled; optionally drops clken every third cycle.
   task automatic countBusy(input bit toggle, output int n);
      n = 0;
      for (int c = 0; c < 200; c++) begin
         clken = toggle ? (c % 3 != 1) : 1'b1;
         @(negedge clk);
         if (!busy) break;
         if (clken) n++;
         tick();
      end
      tick();
      clken = 1'b1;
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] got [8];
      int          n, ptr, ng, op;

      #2 reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      countBusy(1'b0, n);
      checkOutput("clear_busy_cycles", 32'(n), 32'd20);

      for (int a = 0; a < DEPTH; a++) begin
         readWord(0, ADDR_W'(a), d);
         checkOutput("clear_word_zero", d, 32'h0);
      end

      writeWord(0, 5'd5, 4'hF, 32'hDEADBEEF);
      writeWord(0, 5'd5, 4'h3, 32'h0000CAFE);
      readWord(1, 5'd5, d);
      checkOutput("byteenable_merge", d, 32'hDEADCAFE);

      applyStimulus(0, 1'b1, 1'b0, 1'b1, 5'd7, 4'hF, 32'h11111111);
      applyStimulus(1, 1'b1, 1'b0, 1'b1, 5'd7, 4'hF, 32'h22222222);
      tick();
      idleBoth();
      readWord(1, 5'd7, d);
      checkOutput("dual_write_s1_wins", d, 32'h11111111);
      @(negedge clk);
      checkOutput("collision_count_one", 32'(collision_cnt), 32'd1);
      tick();

      readWord(0, 5'd25, d);
      checkOutput("oor_read_zero", d, 32'h0);
      writeWord(0, 5'd20, 4'hF, 32'hFFFFFFFF);
      readWord(0, 5'd0, d);
      checkOutput("oor_write_addr0", d, 32'h0);
      readWord(0, 5'd4, d);
      checkOutput("oor_write_addr4", d, 32'h0);

      for (int i = 0; i < 4; i++) writeWord(0, ADDR_W'(i), 4'hF, 32'hA5A50000 + 32'(i));
      ptr = 0;
      ng = 0;
      for (int c = 0; c < 16; c++) begin
         clken = !(c >= 2 && c <= 4);
         if (ptr < 4) applyStimulus(1, 1'b1, 1'b1, 1'b0, ADDR_W'(ptr), '0, '0);
         else applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
         @(negedge clk);
         if (s2_readdatavalid && clken) begin
            if (ng < 8) got[ng] = s2_readdata;
            ng++;
         end
         @(posedge clk);
         if (clken && ptr < 4) ptr++;
         #1;
      end
      clken = 1'b1;
      checkOutput("burst_pulse_count", 32'(ng), 32'd4);
      for (int i = 0; i < 4; i++) checkOutput("burst_data", got[i], 32'hA5A50000 + 32'(i));

      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (8) tick();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      countBusy(1'b1, n);
      checkOutput("restart_clear_cycles", 32'(n), 32'd20);

      for (int c = 0; c < 800; c++) begin
         clken = ($urandom % 10) != 0;
         for (int p = 0; p < 2; p++) begin
            op = int'($urandom % 4);
            applyStimulus(p, ($urandom % 4) != 0, op[0], op[1],
                          (($urandom % 4) == 0) ? ADDR_W'($urandom % 32) : ADDR_W'($urandom % 8),
                          4'($urandom), $urandom);
         end
         tick();
      end
      idleBoth();
      clken = 1'b1;
      repeat (4) tick();

      applyStimulus(0, 1'b1, 1'b1, 1'b0, 5'd3, '0, '0);
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 5'd9, '0, '0);
      tick();
      idleBoth();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      countBusy(1'b0, n);
      checkOutput("post_flight_clear_cycles", 32'(n), 32'd20);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
